// File: rtl/mux_scan.sv
// Registered N-channel, W-bit selector with manual select and round-robin auto-scan.
// Scan holds each channel for DWELL enabled cycles and flags the N-1 -> 0 wrap.
module mux_scan #(
  parameter int W     = 8,
  parameter int N     = 8,
  parameter int DWELL = 4,
  localparam int SW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           en,
  output logic [W-1:0]   y,
  output logic [SW-1:0]  ch,
  output logic           valid,
  output logic           wrap
);

  localparam int            DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW:0]   NUM   = (SW+1)'(N);
  localparam logic [SW-1:0] LAST  = SW'(N-1);
  localparam logic [DW-1:0] DLAST = DW'(DWELL-1);

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t          state, state_p0;
  logic [DW-1:0]   dwell, dwell_p0;
  logic [W-1:0]    y_p0;
  logic [SW-1:0]   ch_p0;
  logic            valid_p0, wrap_p0;
  logic [W-1:0]    chan [N];

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign chan[k] = in[k*W +: W];
  end

  // Stage p0: next-state and next-output selection
  always_comb begin
    state_p0 = state;
    dwell_p0 = dwell;
    ch_p0    = ch;
    y_p0     = y;
    valid_p0 = 1'b0;
    wrap_p0  = 1'b0;
    if (en) begin
      if (!mode) begin
        state_p0 = MANUAL;
        dwell_p0 = '0;
        if ({1'b0, sel} < NUM) begin
          y_p0     = chan[sel];
          ch_p0    = sel;
          valid_p0 = 1'b1;
        end else begin
          y_p0 = '0;
        end
      end else if (state == MANUAL) begin
        state_p0 = SCAN;
        dwell_p0 = '0;
        ch_p0    = '0;
        y_p0     = chan[0];
        valid_p0 = 1'b1;
      end else begin
        valid_p0 = 1'b1;
        if (dwell == DLAST) begin
          dwell_p0 = '0;
          if (ch == LAST) begin
            ch_p0   = '0;
            wrap_p0 = 1'b1;
          end else begin
            ch_p0 = ch + SW'(1);
          end
        end else begin
          dwell_p0 = dwell + DW'(1);
        end
        // ch only ever holds legal indices in scan, so this lookup is in range
        y_p0 = chan[ch_p0];
      end
    end
  end

  // Stage p1: output and state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MANUAL;
      dwell <= '0;
      ch    <= '0;
      y     <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_p0;
      dwell <= dwell_p0;
      ch    <= ch_p0;
      y     <= y_p0;
      valid <= valid_p0;
      wrap  <= wrap_p0;
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: two instances (N=8/DWELL=4 and N=5/DWELL=1) checked against a
// scan-count reference model, plus table vectors and directed corner-case sequences.
module tb_mux_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in0;
  logic [39:0] in1;
  logic [2:0]  sel   [2];
  logic        mode  [2];
  logic        en    [2];
  logic [7:0]  y     [2];
  logic [2:0]  ch    [2];
  logic        valid [2];
  logic        wrap  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_scan #(.W(8), .N(8), .DWELL(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(in0), .sel(sel[0]), .mode(mode[0]), .en(en[0]),
    .y(y[0]), .ch(ch[0]), .valid(valid[0]), .wrap(wrap[0])
  );

  mux_scan #(.W(8), .N(5), .DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel[1]), .mode(mode[1]), .en(en[1]),
    .y(y[1]), .ch(ch[1]), .valid(valid[1]), .wrap(wrap[1])
  );

  // Reference model: scan position derived from count of enabled scan cycles
  int NN [2] = '{8, 5};
  int DD [2] = '{4, 1};
  bit m_scan  [2];
  int m_k     [2];
  int m_ch    [2];
  int m_y     [2];
  bit m_valid [2];
  bit m_wrap  [2];

  function automatic int chan_of(int d, int c);
    if (d == 0) return int'(in0[c*8 +: 8]);
    return int'(in1[c*8 +: 8]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_scan[d] = 0; m_k[d] = 0; m_ch[d] = 0; m_y[d] = 0; m_valid[d] = 0; m_wrap[d] = 0;
    end
  endtask

  task automatic model_step(int d);
    if (!en[d]) begin
      m_valid[d] = 0;
      m_wrap[d]  = 0;
    end else if (!mode[d]) begin
      m_scan[d] = 0;
      m_wrap[d] = 0;
      if (int'(sel[d]) < NN[d]) begin
        m_ch[d] = int'(sel[d]); m_y[d] = chan_of(d, m_ch[d]); m_valid[d] = 1;
      end else begin
        m_y[d] = 0; m_valid[d] = 0;
      end
    end else if (!m_scan[d]) begin
      m_scan[d] = 1; m_k[d] = 0; m_ch[d] = 0; m_y[d] = chan_of(d, 0);
      m_valid[d] = 1; m_wrap[d] = 0;
    end else begin
      m_k[d]++;
      m_ch[d]    = (m_k[d] / DD[d]) % NN[d];
      m_wrap[d]  = (m_k[d] % (NN[d] * DD[d])) == 0;
      m_y[d]     = chan_of(d, m_ch[d]);
      m_valid[d] = 1;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d.y", d),     32'(y[d]),     32'(m_y[d]));
      chk($sformatf("d%0d.ch", d),    32'(ch[d]),    32'(m_ch[d]));
      chk($sformatf("d%0d.valid", d), 32'(valid[d]), 32'(m_valid[d]));
      chk($sformatf("d%0d.wrap", d),  32'(wrap[d]),  32'(m_wrap[d]));
    end
  endtask

  typedef struct {
    logic [2:0] sel;
    logic       en;
    logic [7:0] ey;
    logic [2:0] ech;
    logic       ev;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{3'(i), 1'b1, 8'(i), 3'(i), 1'b1};
    tbl[8] = '{3'd3, 1'b0, 8'd7, 3'd7, 1'b0};
    tbl[9] = '{3'd5, 1'b1, 8'd5, 3'd5, 1'b1};

    rst_n = 1'b0;
    in0 = 64'h0706050403020100;
    in1 = 40'h2423222120;
    for (int d = 0; d < 2; d++) begin
      sel[d] = '0; mode[d] = 1'b0; en[d] = 1'b0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst.d%0d.y", d),     32'(y[d]),     0);
      chk($sformatf("rst.d%0d.ch", d),    32'(ch[d]),    0);
      chk($sformatf("rst.d%0d.valid", d), 32'(valid[d]), 0);
      chk($sformatf("rst.d%0d.wrap", d),  32'(wrap[d]),  0);
    end
    rst_n = 1'b1;

    // Manual sweep from table
    for (int i = 0; i < 10; i++) begin
      sel[0] = tbl[i].sel; en[0] = tbl[i].en; mode[0] = 1'b0;
      step();
      chk($sformatf("tbl%0d.y", i),     32'(y[0]),     32'(tbl[i].ey));
      chk($sformatf("tbl%0d.ch", i),    32'(ch[0]),    32'(tbl[i].ech));
      chk($sformatf("tbl%0d.valid", i), 32'(valid[0]), 32'(tbl[i].ev));
    end

    // Auto-scan, full period plus the wrap cycle
    en[0] = 1'b1; mode[0] = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      step();
      chk($sformatf("scan%0d.ch", i),   32'(ch[0]),   32'((i / 4) % 8));
      chk($sformatf("scan%0d.wrap", i), 32'(wrap[0]), 32'(i == 32));
    end

    // Enable freeze at ch=3, dwell=2
    mode[0] = 1'b0; sel[0] = 3'd0;
    step();
    mode[0] = 1'b1;
    for (int i = 0; i <= 14; i++) step();
    chk("frz.pre.ch", 32'(ch[0]), 3);
    en[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("frz.ch", 32'(ch[0]), 3);
      chk("frz.y", 32'(y[0]), 3);
      chk("frz.valid", 32'(valid[0]), 0);
    end
    en[0] = 1'b1;
    step();
    chk("frz.resume.ch", 32'(ch[0]), 3);
    chk("frz.resume.valid", 32'(valid[0]), 1);
    step();
    chk("frz.adv.ch", 32'(ch[0]), 4);

    // Mode switch mid-scan, then re-entry
    repeat (4) step();
    chk("msw.pre.ch", 32'(ch[0]), 5);
    mode[0] = 1'b0; sel[0] = 3'd2;
    step();
    chk("msw.man.ch", 32'(ch[0]), 2);
    chk("msw.man.y", 32'(y[0]), 2);
    mode[0] = 1'b1;
    step();
    chk("msw.reentry.ch", 32'(ch[0]), 0);
    repeat (4) step();
    chk("arst.pre.ch", 32'(ch[0]), 1);

    // Asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.y", 32'(y[0]), 0);
    chk("arst.ch", 32'(ch[0]), 0);
    chk("arst.valid", 32'(valid[0]), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode[0] = 1'b0; en[0] = 1'b0;

    // Non-power-of-2 channel count, illegal manual select
    en[1] = 1'b1; mode[1] = 1'b0; sel[1] = 3'd2;
    step();
    chk("np2.ch", 32'(ch[1]), 2);
    chk("np2.y", 32'(y[1]), 32'(in1[23:16]));
    sel[1] = 3'd6;
    step();
    chk("np2.bad.y", 32'(y[1]), 0);
    chk("np2.bad.valid", 32'(valid[1]), 0);
    chk("np2.bad.ch", 32'(ch[1]), 2);

    // DWELL=1 scan with data changing between every edge
    mode[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in1 = 40'({$urandom(), $urandom()});
      step();
      chk($sformatf("d1scan%0d.ch", i),   32'(ch[1]),   32'(i % 5));
      chk($sformatf("d1scan%0d.wrap", i), 32'(wrap[1]), 32'(i > 0 && i % 5 == 0));
      chk($sformatf("d1scan%0d.y", i),    32'(y[1]),    32'(in1[(i % 5) * 8 +: 8]));
    end

    // Randomized traffic on both instances
    for (int n = 0; n < 600; n++) begin
      in0 = {$urandom(), $urandom()};
      in1 = 40'({$urandom(), $urandom()});
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 15) == 0) mode[d] = ~mode[d];
        en[d]  = ($urandom_range(0, 7) != 0);
        sel[d] = 3'($urandom_range(0, 7));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N-channel, W-bit multiplexer with two modes: manual select, and auto-scan, which steps through every channel in round-robin order with a programmable dwell. It extends the fixed 8:1 single-bit part-select mux into a generalised, clocked channel selector. It sits between a bank of parallel sources (sensors, test patterns) and a single downstream consumer, such as a display, serialiser or logger.

## Interface
Parameters:
- W, 8, data width per channel (≥1)
- N, 8, channel count (2..256; need not be a power of 2)
- DWELL, 4, cycles each channel is held in scan mode (≥1)
- SW (localparam), $clog2(N), width of select/channel index

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in  in  N*W  packed channel data; channel k = in[k*W +: W]
- sel  in  SW  manual channel select
- mode  in  1  0 = manual, 1 = auto-scan
- en  in  1  clock enable; low freezes all state
- y  out  W  registered selected data
- ch  out  SW  channel index that produced the current y
- valid  out  1  y/ch hold a legal, freshly sampled channel
- wrap  out  1  one-cycle pulse: scan wrapped N-1 → 0

## Operation
- Reset (rst_n low, asynchronous):
  - y=0, ch=0, valid=0, wrap=0.
  - Dwell counter=0; state=MANUAL.
- States:
  - MANUAL when mode=0; SCAN when mode=1. The state register tracks mode on each enabled clock.
- MANUAL, en=1:
  - sel < N: y ← in[sel*W +: W], ch ← sel, valid ← 1.
  - sel ≥ N (non-power-of-2 N only): y ← 0, ch ← ch (held), valid ← 0.
  - wrap=0 throughout.
- Entering SCAN (state MANUAL, mode=1, en=1):
  - ch ← 0, y ← in[0 +: W], dwell ← 0, valid ← 1.
  - No wrap pulse.
- SCAN, en=1, each cycle: y ← in[ch_next*W +: W].
  - Data is resampled every cycle, so y tracks live changes on the held channel.
  - Dwell counts 0..DWELL-1.
  - At DWELL-1: dwell ← 0 and ch ← ch+1.
  - If ch = N-1 at that point: ch ← 0 and wrap ← 1 for that cycle.
  - valid=1 throughout.
- SCAN → MANUAL (mode=0, en=1): the next cycle behaves as MANUAL; the scan position is discarded.
- en=0:
  - y, ch, dwell and state hold.
  - valid ← 0 and wrap ← 0.
  - On re-enable, scan resumes at the held ch/dwell.
- DWELL=1: channel advances every enabled cycle; wrap pulses every N enabled cycles.
- sel is ignored in SCAN.

## Timing
- Latency 1 cycle: inputs sampled at edge t appear on y/ch/valid after edge t.
- Each channel appears in SCAN for exactly DWELL consecutive enabled cycles.
- Full scan period is N*DWELL enabled cycles.
- wrap is asserted in the same cycle that ch first shows 0 after N-1. It is high for exactly one enabled cycle.
- Simultaneous mode=1 and en=0: no state change; the SCAN entry happens on the first cycle with en=1.
- Reset mid-scan forces outputs to 0 immediately (asynchronous). Restart is the first clock after rst_n rises, in MANUAL state.
- No combinational path from inputs to outputs.

## Test plan
- Reset and manual sweep (W=8, N=8, in=64'h0706050403020100):
  - Assert rst_n=0 → y=0, ch=0, valid=0.
  - Release, then sel 0..7 with en=1 → y equals sel one cycle later, ch=sel, valid=1.
- Auto-scan (N=8, DWELL=4):
  - mode=1 → ch sequence 0,0,0,0,1,1,1,1,…,7,7,7,7,0.
  - wrap high only on the first ch=0 after 7, i.e. period 32 cycles.
- Enable freeze:
  - Mid-scan at ch=3 with dwell=2, drop en for 5 cycles → y/ch held, valid=0.
  - On re-enable, ch=3 holds for 1 more cycle before 4.
- Non-power-of-2 (N=5, SW=3):
  - Manual sel=6 → y=0, valid=0, ch unchanged.
  - Scan → ch wraps 4→0, never reaches 5..7.
- Mode switch and async reset:
  - Scan to ch=5, set mode=0 with sel=2 → next cycle ch=2.
  - Re-enter scan → restarts at ch=0.
  - Pulse rst_n low mid-cycle → outputs 0 before the next clock edge.
- DWELL=1 live data:
  - ch advances every cycle; wrap every N cycles.
  - Change in[ch] between edges → new value appears on y at the next edge.
